// File: rtl/rfifo_pkg.sv
// Shared pointer helpers for both sides of the async FIFO. Both controllers must use
// these same conversions so the Gray pointers they exchange stay compatible.
package rfifo_pkg;

  localparam int P_DEFAULT = 4;
  localparam int A_DEFAULT = 3;

  // Widest pointer the helpers handle; callers zero-extend and truncate to their width.
  localparam int PTR_MAX_W = 16;
  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    ptr_max_t gray;
    for (int i = 0; i < PTR_MAX_W - 1; i++) begin
      gray[i] = bin[i] ^ bin[i+1];
    end
    gray[PTR_MAX_W-1] = bin[PTR_MAX_W-1];
    return gray;
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rfifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: pop request, synchronised write pointer in;
// flags, RAM read address/strobe and published Gray read pointer out.
interface rfifo_rd_ctrl_if
  import rfifo_pkg::*;
#(
  parameter int P = P_DEFAULT,
  parameter int A = A_DEFAULT
);

  logic         rinc;
  logic [P-1:0] s_g_wptr;
  logic         rempty;
  logic [A-1:0] raddr;
  logic         rd_en;
  logic [P-1:0] g_rptr;
  logic         ralmost_empty;
  logic [P-1:0] rlevel;

  modport master (
    input  rinc, s_g_wptr,
    output rempty, raddr, rd_en, g_rptr, ralmost_empty, rlevel
  );

  modport slave (
    output rinc, s_g_wptr,
    input  rempty, raddr, rd_en, g_rptr, ralmost_empty, rlevel
  );

endinterface

// File: rtl/gray_to_bin.sv
// P-bit Gray-to-binary converter (XOR prefix from the MSB down).
// Only compiled when RFIFO_AEMPTY_EN is defined, since nothing else needs it.
`ifdef RFIFO_AEMPTY_EN
module gray_to_bin #(
  parameter int P = 4
) (
  input  logic [P-1:0] gray,
  output logic [P-1:0] bin
);

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_bit
      assign bin[gi] = ^gray[P-1:gi];
    end
  endgenerate

endmodule
`endif

// File: rtl/rfifo_rd_ctrl.sv
// Read-side pointer/flag controller of the async FIFO (rclk domain).
// Define RFIFO_AEMPTY_EN to add the registered fill level and almost-empty flag.
module rfifo_rd_ctrl
  import rfifo_pkg::*;
#(
  parameter int P         = P_DEFAULT,
  parameter int A         = A_DEFAULT,
  parameter int AE_THRESH = 1
) (
  input  logic           rclk,
  input  logic           rrst,
  rfifo_rd_ctrl_if.master bus
);

  logic [P-1:0] rptr_reg;
  logic [P-1:0] rptr_next;
  logic [P-1:0] g_rptr_reg;
  logic [P-1:0] g_rptr_next;
  logic         rempty_reg;
  logic         rempty_next;
  logic         pop;

  // Empty is judged on the pointer after this edge's pop, so popping the last
  // word raises rempty on the same edge and a second read can never slip through.
  always_comb begin
    pop         = bus.rinc & ~rempty_reg;
    rptr_next   = rptr_reg + {{(P-1){1'b0}}, pop};
    g_rptr_next = P'(bin2gray(PTR_MAX_W'(rptr_next)));
    rempty_next = (g_rptr_next == bus.s_g_wptr);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rptr_reg   <= '0;
      g_rptr_reg <= '0;
      rempty_reg <= 1'b1;
    end else begin
      rptr_reg   <= rptr_next;
      g_rptr_reg <= g_rptr_next;
      rempty_reg <= rempty_next;
    end
  end

  assign bus.raddr  = rptr_reg[A-1:0];
  assign bus.rd_en  = pop;
  assign bus.g_rptr = g_rptr_reg;
  assign bus.rempty = rempty_reg;

`ifdef RFIFO_AEMPTY_EN
  localparam logic [P-1:0] AE_THRESH_P = P'(AE_THRESH);

  logic [P-1:0] wbin;
  logic [P-1:0] rlevel_next;
  logic [P-1:0] rlevel_reg;
  logic         ralmost_empty_reg;

  gray_to_bin #(.P(P)) u_gray_to_bin (
    .gray (bus.s_g_wptr),
    .bin  (wbin)
  );

  // Modulo-2**P difference handles the wrap bit naturally.
  assign rlevel_next = wbin - rptr_next;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rlevel_reg        <= '0;
      ralmost_empty_reg <= 1'b1;
    end else begin
      rlevel_reg        <= rlevel_next;
      ralmost_empty_reg <= (rlevel_next <= AE_THRESH_P);
    end
  end

  assign bus.rlevel        = rlevel_reg;
  assign bus.ralmost_empty = ralmost_empty_reg;
`else
  assign bus.rlevel        = '0;
  assign bus.ralmost_empty = rempty_reg;
`endif

endmodule

// File: tb/tb_rfifo_rd_ctrl.sv
// Directed bench for rfifo_rd_ctrl: reset, single pop, ignored pops when empty,
// full pointer wrap, mid-stream reset and (with RFIFO_AEMPTY_EN) level/almost-empty.
module tb_rfifo_rd_ctrl;

  localparam logic [3:0] GRAY [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                      4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rfifo_rd_ctrl_if #(.P(4), .A(3)) bus ();

  rfifo_rd_ctrl #(.P(4), .A(3), .AE_THRESH(1)) dut (
    .rclk (clk),
    .rrst (rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one edge and settle, so outputs are read 1ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rptr_m;
    int nxt;
    checks = 0;
    errors = 0;

    // 1: reset held for two edges
    rst = 1'b1;
    bus.rinc = 1'b0;
    bus.s_g_wptr = 4'h0;
    tick();
    tick();
    check("rst_rempty", 32'(bus.rempty), 32'd1);
    check("rst_raddr", 32'(bus.raddr), 32'd0);
    check("rst_g_rptr", 32'(bus.g_rptr), 32'd0);
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_rlevel", 32'(bus.rlevel), 32'd0);
    check("rst_ralmost", 32'(bus.ralmost_empty), 32'd1);
    rst = 1'b0;
    tick();
    check("idle_rempty", 32'(bus.rempty), 32'd1);

    // 2: one word written, one pop
    bus.s_g_wptr = 4'b0001;
    tick();
    check("t2_rempty_clr", 32'(bus.rempty), 32'd0);
    bus.rinc = 1'b1;
    #1;
    check("t2_rd_en", 32'(bus.rd_en), 32'd1);
    check("t2_raddr_pre", 32'(bus.raddr), 32'd0);
    tick();
    check("t2_raddr", 32'(bus.raddr), 32'd1);
    check("t2_g_rptr", 32'(bus.g_rptr), 32'b0001);
    check("t2_rempty_set", 32'(bus.rempty), 32'd1);

    // 3: pops while empty are ignored
    for (int i = 0; i < 5; i++) begin
      check("t3_rd_en", 32'(bus.rd_en), 32'd0);
      tick();
      check("t3_g_rptr", 32'(bus.g_rptr), 32'b0001);
      check("t3_raddr", 32'(bus.raddr), 32'd1);
    end

    // 4: walk the write pointer through 16 codes, rinc held high
    rptr_m = 1;
    for (int k = 0; k < 16; k++) begin
      nxt = (rptr_m + 1) % 16;
      bus.s_g_wptr = GRAY[nxt];
      tick();
      check("t4_rempty_clr", 32'(bus.rempty), 32'd0);
      check("t4_rd_en", 32'(bus.rd_en), 32'd1);
      tick();
      rptr_m = nxt;
      check("t4_g_rptr", 32'(bus.g_rptr), 32'(GRAY[rptr_m]));
      check("t4_raddr", 32'(bus.raddr), 32'(rptr_m % 8));
      check("t4_rempty_set", 32'(bus.rempty), 32'd1);
    end

    // 5: reset mid-stream with rinc high
    bus.rinc = 1'b0;
    bus.s_g_wptr = GRAY[9];
    tick();
    check("t5_rempty_clr", 32'(bus.rempty), 32'd0);
    bus.rinc = 1'b1;
    repeat (4) tick();
    check("t5_raddr", 32'(bus.raddr), 32'd5);
    check("t5_g_rptr", 32'(bus.g_rptr), 32'(GRAY[5]));
    check("t5_rempty", 32'(bus.rempty), 32'd0);
    rst = 1'b1;
    tick();
    check("t5_rst_raddr", 32'(bus.raddr), 32'd0);
    check("t5_rst_g_rptr", 32'(bus.g_rptr), 32'd0);
    check("t5_rst_rempty", 32'(bus.rempty), 32'd1);
    check("t5_rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("t5_rst_rlevel", 32'(bus.rlevel), 32'd0);
    check("t5_rst_ralmost", 32'(bus.ralmost_empty), 32'd1);
    rst = 1'b0;
    tick();
    check("t5_post_rempty", 32'(bus.rempty), 32'd0);
    check("t5_post_raddr", 32'(bus.raddr), 32'd0);
    check("t5_post_rd_en", 32'(bus.rd_en), 32'd1);
`ifndef RFIFO_AEMPTY_EN
    check("t5_rlevel_tied", 32'(bus.rlevel), 32'd0);
    check("t5_ralmost_tied", 32'(bus.ralmost_empty), 32'd0);
`endif

`ifdef RFIFO_AEMPTY_EN
    // 6: level and almost-empty with threshold 1
    rst = 1'b1;
    bus.rinc = 1'b0;
    bus.s_g_wptr = 4'h0;
    tick();
    rst = 1'b0;
    bus.s_g_wptr = 4'b0110;
    tick();
    check("t6_rlevel4", 32'(bus.rlevel), 32'd4);
    check("t6_ralmost0", 32'(bus.ralmost_empty), 32'd0);
    check("t6_rempty0", 32'(bus.rempty), 32'd0);
    bus.rinc = 1'b1;
    repeat (3) tick();
    check("t6_rlevel1", 32'(bus.rlevel), 32'd1);
    check("t6_ralmost1", 32'(bus.ralmost_empty), 32'd1);
    check("t6_rempty_still0", 32'(bus.rempty), 32'd0);
    tick();
    check("t6_rlevel0", 32'(bus.rlevel), 32'd0);
    check("t6_rempty1", 32'(bus.rempty), 32'd1);
    check("t6_ralmost_end", 32'(bus.ralmost_empty), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
